// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- definitions shared by the UART transmitter and receiver.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - cycles_per_bit(): clock cycles per line bit (integer division)
//   - timer_width(): counter width that holds a given cycle count untruncated
//   - uart_tx_dbg_t: debug view of the transmitter FSM
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width needed to count 0 .. max_cycles-1 and to hold max_cycles itself
  // as a terminal-count value.
  function automatic int timer_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] bit_idx;
  } uart_tx_dbg_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- request/ready bundle between a byte source and uart_tx.
//   tx_en    : request to send tx_data
//   tx_data  : byte to send, sampled only on the accepting edge
//   tx_break : request to send a break (ignored when tx_en is high)
//   tx_ready : transmitter idle
// Handshake: a request is accepted on a rising clk edge where tx_ready is
// high; tx_en wins over tx_break. Requests while tx_ready is low are ignored,
// so the source may hold or toggle them freely during a frame.
interface uart_tx_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_break;
  logic       tx_ready;

  modport master (output tx_en, output tx_data, output tx_break, input tx_ready);
  modport slave  (input tx_en, input tx_data, input tx_break, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer -- free-running cycle counter with a programmable terminal
// count, shared by the UART transmitter and receiver.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : hold the counter at 0 (no done while asserted)
//   load        : terminal count; done pulses on the load-th cycle after clear
//   done        : one-cycle pulse; the counter wraps to 0 on the same edge
module uart_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = !clear && (cnt == (load - W'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1/8N2 UART transmitter with break generation.
//   clk      : system clock
//   resetn   : asynchronous active-low reset
//   bus      : uart_tx_if.slave (tx_en, tx_data, tx_break in; tx_ready out)
//   uart_txd : registered serial output, idle high
//   dbg      : current FSM state and data bit index
// uart_txd is loaded with the level of the state being entered, so the line
// changes on the same edge as the state (one cycle after acceptance).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_RATE   = 9600,
  parameter int CLK_HZ     = 100000000,
  parameter int STOP_BITS  = 1,
  parameter int BREAK_BITS = 13
) (
  input  logic         clk,
  input  logic         resetn,
  uart_tx_if.slave     bus,
  output logic         uart_txd,
  output uart_tx_dbg_t dbg
);

  localparam int CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int STOP_CYC = (STOP_BITS == 2) ? 2 * CPB : CPB;
  localparam int BRK_CYC  = CPB * BREAK_BITS;
  localparam int MAX_CYC  = (BRK_CYC > STOP_CYC) ? BRK_CYC : STOP_CYC;
  localparam int CW       = timer_width(MAX_CYC);

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CPB);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CYC);
  localparam logic [CW-1:0] BRK_LOAD  = CW'(BRK_CYC);

  logic [2:0]    state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          timer_clear;
  logic          timer_done;
  logic [CW-1:0] timer_load;

  // Counter idles at 0 so the first bit-time after acceptance is full length.
  assign timer_clear  = (state == ST_IDLE);
  assign bus.tx_ready = (state == ST_IDLE);
  assign dbg.state    = state;
  assign dbg.bit_idx  = bit_idx;

  always_comb begin
    timer_load = BIT_LOAD;
    case (state)
      ST_STOP:  timer_load = STOP_LOAD;
      ST_BREAK: timer_load = BRK_LOAD;
      default:  timer_load = BIT_LOAD;
    endcase
  end

  uart_bit_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (timer_clear),
    .load   (timer_load),
    .done   (timer_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      uart_txd <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_idx <= 3'd0;
          if (bus.tx_en) begin
            state    <= ST_START;
            shift    <= bus.tx_data;
            uart_txd <= 1'b0;
          end else if (bus.tx_break) begin
            state    <= ST_BREAK;
            uart_txd <= 1'b0;
          end else begin
            uart_txd <= 1'b1;
          end
        end
        ST_START: begin
          if (timer_done) begin
            state    <= ST_DATA;
            bit_idx  <= 3'd0;
            uart_txd <= shift[0];
          end
        end
        ST_DATA: begin
          if (timer_done) begin
            if (bit_idx == 3'd7) begin
              state    <= ST_STOP;
              uart_txd <= 1'b1;
            end else begin
              // shift[1] becomes shift[0] on this edge; drive it now.
              shift    <= {1'b0, shift[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shift[1];
            end
          end
        end
        ST_STOP: begin
          if (timer_done) begin
            state    <= ST_IDLE;
            uart_txd <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (timer_done) begin
            state    <= ST_STOP;
            uart_txd <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bit_idx  <= 3'd0;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx at 10 clock cycles per bit.
// Expected line/ready levels per cycle are built from the frame format into
// exp_q ({tx_ready, uart_txd}) and compared on falling clock edges.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CPB = 10;

  logic         clk;
  logic         resetn;
  logic         uart_txd;
  uart_tx_dbg_t dbg;
  uart_tx_if    bus ();

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  uart_tx #(
    .BIT_RATE   (100000),
    .CLK_HZ     (1000000),
    .STOP_BITS  (1),
    .BREAK_BITS (13)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .uart_txd (uart_txd),
    .dbg      (dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected-waveform builders
  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < CPB; i++) exp_q.push_back(2'b00);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < CPB; i++) exp_q.push_back({1'b0, d[b]});
    for (int i = 0; i < CPB; i++) exp_q.push_back(2'b01);
  endtask

  task automatic push_break();
    for (int i = 0; i < 13 * CPB; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < CPB; i++) exp_q.push_back(2'b01);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b11);
  endtask

  // Pops up to max_n entries, one per falling edge. After sampling entry
  // release_at, all requests drop; at noise_lo, tx_en/tx_break rise with
  // noise_data; at noise_hi they drop again (-1 disables a hook).
  task automatic run_check(input int max_n, input int release_at,
                           input int noise_lo, input int noise_hi,
                           input logic [7:0] noise_data);
    int idx;
    logic [1:0] e;
    idx = 0;
    while (exp_q.size() > 0 && idx < max_n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("txd[%0d]", idx), {31'd0, uart_txd}, {31'd0, e[0]});
      check_eq($sformatf("tx_ready[%0d]", idx), {31'd0, bus.tx_ready}, {31'd0, e[1]});
      if (idx == release_at) begin
        bus.tx_en    = 1'b0;
        bus.tx_break = 1'b0;
      end
      if (idx == noise_lo) begin
        bus.tx_en    = 1'b1;
        bus.tx_break = 1'b1;
        bus.tx_data  = noise_data;
      end
      if (idx == noise_hi) begin
        bus.tx_en    = 1'b0;
        bus.tx_break = 1'b0;
      end
      idx++;
    end
  endtask

  task automatic drive_req(input logic en, input logic brk, input logic [7:0] d);
    bus.tx_en    = en;
    bus.tx_break = brk;
    bus.tx_data  = d;
  endtask

  initial begin
    resetn = 1'b1;
    drive_req(1'b0, 1'b0, 8'h00);
    #2 resetn = 1'b0;
    #1;
    check_eq("reset_txd", {31'd0, uart_txd}, 32'd1);
    check_eq("reset_ready", {31'd0, bus.tx_ready}, 32'd1);
    check_eq("reset_state", {29'd0, dbg.state}, {29'd0, ST_IDLE});
    check_eq("reset_bit_idx", {29'd0, dbg.bit_idx}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    push_idle(3);
    run_check(1000, -1, -1, -1, 8'h00);

    // 0xA5 single frame, ready returns after 100 busy cycles
    drive_req(1'b1, 1'b0, 8'hA5);
    push_frame(8'hA5);
    push_idle(5);
    run_check(1000, 0, -1, -1, 8'h00);

    // back-to-back with tx_en held: 0x00 then 0xFF, one idle cycle between
    drive_req(1'b1, 1'b0, 8'h00);
    push_frame(8'h00);
    push_idle(1);
    push_frame(8'hFF);
    push_idle(5);
    run_check(1000, 200, 0, -1, 8'hFF);
    bus.tx_data = 8'h00;

    // break: 130 low, 10 high, then idle
    drive_req(1'b0, 1'b1, 8'h00);
    push_break();
    push_idle(5);
    run_check(1000, 0, -1, -1, 8'h00);

    // tx_en and tx_break together: frame only, no trailing break
    drive_req(1'b1, 1'b1, 8'h3C);
    push_frame(8'h3C);
    push_idle(20);
    run_check(1000, 0, -1, -1, 8'h00);

    // requests during a frame are ignored
    drive_req(1'b1, 1'b0, 8'hC3);
    push_frame(8'hC3);
    push_idle(15);
    run_check(1000, 0, 30, 40, 8'h00);

    // reset at cycle 45 of a frame, then 0x81 on the first edge after release
    drive_req(1'b1, 1'b0, 8'hA5);
    push_frame(8'hA5);
    run_check(45, 0, -1, -1, 8'h00);
    exp_q.delete();
    resetn = 1'b0;
    #1;
    check_eq("abort_txd", {31'd0, uart_txd}, 32'd1);
    check_eq("abort_ready", {31'd0, bus.tx_ready}, 32'd1);
    check_eq("abort_state", {29'd0, dbg.state}, {29'd0, ST_IDLE});
    push_idle(3);
    run_check(1000, -1, -1, -1, 8'h00);
    resetn = 1'b1;
    drive_req(1'b1, 1'b0, 8'h81);
    push_frame(8'h81);
    push_idle(5);
    run_check(1000, 0, -1, -1, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
